// File: rtl/hamming_secded_decoder.sv
// Two-stage pipelined Hamming SEC-DED decoder for the PUF response path.
// Stage 1 captures the extracted raw data bits, the syndrome and the overall parity.
// Stage 2 applies the single-bit correction and registers the data and the error flags.
// Optional saturating error counters are built only when ECC_ERR_CNT_EN is defined.
// Without the macro, corr_cnt/uncorr_cnt read 0 and cnt_clr is ignored.
module hamming_secded_decoder #(
    parameter int unsigned R     = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:(1<<R)-1] c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:(1<<R)-2-R] data_out,
    output logic             corrected,
    output logic             uncorrectable,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt
);

    localparam int unsigned N = (1 << R) - 1;
    localparam int unsigned K = N - R;

    logic         s1_valid_q, s1_valid_d;
    logic [0:K-1] s1_raw_q, s1_raw_d;
    logic [R-1:0] s1_syn_q, s1_syn_d;
    logic         s1_par_q, s1_par_d;

    logic         s2_valid_q, s2_valid_d;
    logic [0:K-1] data_q, data_d;
    logic         corr_q, corr_d;
    logic         uncorr_q, uncorr_d;

    logic [0:K-1] raw_c;
    logic [R-1:0] syn_c;
    logic [0:K-1] fixed_c;
    logic         s2_load;

    // Syndrome, overall parity and raw data extraction straight from the input word
    always_comb begin
        int k;
        syn_c = '0;
        raw_c = '0;
        k     = 0;
        for (int p = 1; p <= int'(N); p++) begin
            if (c_in[p-1]) syn_c = syn_c ^ R'(p);
            if ((p & (p - 1)) != 0) begin
                raw_c[k] = c_in[p-1];
                k++;
            end
        end
    end

    // Single-error correction of the stage-1 data: flip the bit whose position matches s
    always_comb begin
        int k;
        fixed_c = '0;
        k       = 0;
        for (int p = 1; p <= int'(N); p++) begin
            if ((p & (p - 1)) != 0) begin
                fixed_c[k] = s1_raw_q[k] ^ (s1_par_q && (s1_syn_q == R'(p)));
                k++;
            end
        end
    end

    // Handshake and next-state for both pipeline stages
    always_comb begin
        s2_load    = !s2_valid_q || out_ready;
        in_ready   = !rst && (!s1_valid_q || s2_load);

        s1_valid_d = s1_valid_q;
        s1_raw_d   = s1_raw_q;
        s1_syn_d   = s1_syn_q;
        s1_par_d   = s1_par_q;
        s2_valid_d = s2_valid_q;
        data_d     = data_q;
        corr_d     = corr_q;
        uncorr_d   = uncorr_q;

        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_raw_d = raw_c;
                s1_syn_d = syn_c;
                s1_par_d = ^c_in;
            end
        end

        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                data_d   = fixed_c;
                corr_d   = s1_par_q;
                uncorr_d = !s1_par_q && (s1_syn_q != '0);
            end
        end
    end

    // Pipeline registers
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_raw_q   <= '0;
            s1_syn_q   <= '0;
            s1_par_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            data_q     <= '0;
            corr_q     <= 1'b0;
            uncorr_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_raw_q   <= s1_raw_d;
            s1_syn_q   <= s1_syn_d;
            s1_par_q   <= s1_par_d;
            s2_valid_q <= s2_valid_d;
            data_q     <= data_d;
            corr_q     <= corr_d;
            uncorr_q   <= uncorr_d;
        end
    end

    assign out_valid     = s2_valid_q;
    assign data_out      = data_q;
    assign corrected     = corr_q;
    assign uncorrectable = uncorr_q;

`ifdef ECC_ERR_CNT_EN
    logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
    logic [CNT_W-1:0] uncorr_cnt_q, uncorr_cnt_d;
    logic             out_hs;

    // Saturating counts of delivered flagged words; clear wins over increment
    always_comb begin
        out_hs       = s2_valid_q && out_ready;
        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;
        if (cnt_clr) begin
            corr_cnt_d   = '0;
            uncorr_cnt_d = '0;
        end else if (out_hs) begin
            if (corr_q && (corr_cnt_q != '1))     corr_cnt_d   = corr_cnt_q + CNT_W'(1);
            if (uncorr_q && (uncorr_cnt_q != '1)) uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
        end
    end

    assign corr_cnt   = corr_cnt_q;
    assign uncorr_cnt = uncorr_cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign corr_cnt       = '0;
    assign uncorr_cnt     = '0;
`endif

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Self-checking bench for hamming_secded_decoder (R=4, CNT_W=5).
// Expected words come from an encoder/extractor model and from knowledge of the injected errors.
module tb_hamming_secded_decoder;

    localparam int unsigned R     = 4;
    localparam int unsigned CNT_W = 5;
    localparam int unsigned N     = (1 << R) - 1;
    localparam int unsigned K     = N - R;
    localparam int          MAXC  = (1 << CNT_W) - 1;
`ifdef ECC_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct packed {
        logic [0:N]   code;
        logic [0:K-1] data;
        logic         corr;
        logic         uncorr;
    } item_t;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [0:N]       c_in;
    logic             out_valid;
    logic             out_ready;
    logic [0:K-1]     data_out;
    logic             corrected;
    logic             uncorrectable;
    logic             cnt_clr;
    logic [CNT_W-1:0] corr_cnt;
    logic [CNT_W-1:0] uncorr_cnt;

    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    acc_cyc = 0;
    int    last_hs_cyc = 0;
    int    accepted = 0;
    int    delivered = 0;
    int    exp_corr = 0;
    int    exp_uncorr = 0;
    bit    rand_rdy = 0;
    logic  last_in_ready;
    item_t send_q[$];
    item_t exp_q[$];

    hamming_secded_decoder #(.R(R), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .c_in(c_in),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
        .corrected(corrected), .uncorrectable(uncorrectable), .cnt_clr(cnt_clr),
        .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_pow2(input int p);
        return (p & (p - 1)) == 0;
    endfunction

    function automatic logic [0:K-1] extract(input logic [0:N] cw);
        logic [0:K-1] d = '0;
        int k = 0;
        for (int p = 1; p <= int'(N); p++)
            if (!is_pow2(p)) begin d[k] = cw[p-1]; k++; end
        return d;
    endfunction

    function automatic logic [0:N] encode(input logic [0:K-1] d);
        logic [0:N] cw = '0;
        int k = 0;
        for (int p = 1; p <= int'(N); p++)
            if (!is_pow2(p)) begin cw[p-1] = d[k]; k++; end
        for (int j = 0; j < int'(R); j++) begin
            logic b = 1'b0;
            for (int p = 1; p <= int'(N); p++)
                if (((p >> j) & 1) == 1 && p != (1 << j)) b = b ^ cw[p-1];
            cw[(1 << j) - 1] = b;
        end
        cw[N] = ^cw[0:N-1];
        return cw;
    endfunction

    task automatic push(input logic [0:N] cw, input logic [0:K-1] d, input logic c, input logic u);
        item_t it;
        it.code = cw; it.data = d; it.corr = c; it.uncorr = u;
        send_q.push_back(it);
    endtask

    // One clock cycle: drive at the falling edge, observe 1 time unit later, update the model
    task automatic tick();
        item_t it;
        logic  acc, hs;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        if (!rst && send_q.size() > 0) begin
            in_valid = 1'b1;
            c_in     = send_q[0].code;
        end else begin
            in_valid = 1'b0;
            c_in     = (N+1)'({$urandom(), $urandom()});
        end
        #1;
        last_in_ready = in_ready;
        if (rst) chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("corr_cnt", 64'(corr_cnt), 64'(exp_corr));
        chk("uncorr_cnt", 64'(uncorr_cnt), 64'(exp_uncorr));
        acc = !rst && in_valid && in_ready;
        hs  = !rst && out_valid && out_ready;
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) chk("spurious_out", 64'(1), 64'(0));
            else begin
                chk("data_out", 64'(data_out), 64'(exp_q[0].data));
                chk("corrected", 64'(corrected), 64'(exp_q[0].corr));
                chk("uncorrectable", 64'(uncorrectable), 64'(exp_q[0].uncorr));
            end
        end
        if (rst) begin
            exp_corr = 0; exp_uncorr = 0;
            exp_q.delete();
        end else if (cnt_clr && CNT_EN) begin
            exp_corr = 0; exp_uncorr = 0;
        end
        if (hs && exp_q.size() > 0) begin
            it = exp_q.pop_front();
            delivered++;
            last_hs_cyc = cyc;
            if (CNT_EN && !cnt_clr) begin
                if (it.corr)   exp_corr   = (exp_corr == MAXC) ? MAXC : exp_corr + 1;
                if (it.uncorr) exp_uncorr = (exp_uncorr == MAXC) ? MAXC : exp_uncorr + 1;
            end
        end
        if (acc) begin
            it = send_q.pop_front();
            exp_q.push_back(it);
            accepted++;
            acc_cyc = cyc;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain();
        int budget = 0;
        while ((send_q.size() > 0 || exp_q.size() > 0) && budget < 2000) begin
            tick();
            budget++;
        end
        if (budget >= 2000) chk("drain_timeout", 64'(1), 64'(0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        send_q.delete();
    endtask

    initial begin
        logic [0:K-1] pl;
        logic [0:N]   cw;
        int           nf, i1, i2, d0, a0, guard;
        clk = 1'b0; rst = 1'b1; in_valid = 1'b0; c_in = '0;
        out_ready = 1'b0; cnt_clr = 1'b0;
        @(negedge clk);

        // Reset values
        do_reset();
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_data_out", 64'(data_out), 64'(0));
        chk("rst_corrected", 64'(corrected), 64'(0));
        chk("rst_uncorr", 64'(uncorrectable), 64'(0));
        chk("rst_corr_cnt", 64'(corr_cnt), 64'(0));
        chk("rst_uncorr_cnt", 64'(uncorr_cnt), 64'(0));

        // Clean all-zero word, two-cycle latency
        out_ready = 1'b1;
        push('0, '0, 1'b0, 1'b0);
        drain();
        chk("latency", 64'(last_hs_cyc - acc_cyc), 64'(2));

        // Single-error sweep over all 16 bits, including the overall parity bit
        pl = K'($urandom());
        for (int i = 0; i <= int'(N); i++) begin
            cw = encode(pl);
            cw[i] = ~cw[i];
            push(cw, pl, 1'b1, 1'b0);
        end
        drain();
        chk("sweep_corr_cnt", 64'(corr_cnt), CNT_EN ? 64'(16) : 64'(0));

        // Double error at positions 3 and 5
        pl = K'($urandom());
        cw = encode(pl);
        cw[2] = ~cw[2];
        cw[4] = ~cw[4];
        push(cw, extract(cw), 1'b0, 1'b1);
        drain();
        chk("dbl_uncorr_cnt", 64'(uncorr_cnt), CNT_EN ? 64'(1) : 64'(0));

        // Back-pressure: five words against a stalled consumer
        out_ready = 1'b0;
        d0 = delivered; a0 = accepted;
        for (int i = 0; i < 5; i++) begin
            pl = K'($urandom());
            push(encode(pl), pl, 1'b0, 1'b0);
        end
        tick(); tick();
        chk("bp_two_accepted", 64'(accepted - a0), 64'(2));
        tick();
        chk("bp_in_ready_low", 64'(last_in_ready), 64'(0));
        tick();
        chk("bp_still_low", 64'(last_in_ready), 64'(0));
        chk("bp_held_valid", 64'(out_valid), 64'(1));
        out_ready = 1'b1;
        drain();
        chk("bp_delivered", 64'(delivered - d0), 64'(5));

        // Random traffic with 0, 1 or 2 injected errors and random consumer stalls
        rand_rdy = 1'b1;
        for (int i = 0; i < 60; i++) begin
            pl = K'($urandom());
            cw = encode(pl);
            nf = $urandom_range(0, 2);
            i1 = $urandom_range(0, N);
            do i2 = $urandom_range(0, N); while (i2 == i1);
            if (nf >= 1) cw[i1] = ~cw[i1];
            if (nf == 2) cw[i2] = ~cw[i2];
            if (nf == 0)      push(cw, pl, 1'b0, 1'b0);
            else if (nf == 1) push(cw, pl, 1'b1, 1'b0);
            else              push(cw, extract(cw), 1'b0, 1'b1);
        end
        drain();
        rand_rdy = 1'b0;
        out_ready = 1'b1;

        // Saturation of the correction counter
        for (int i = 0; i < MAXC; i++) begin
            pl = K'($urandom());
            cw = encode(pl);
            i1 = $urandom_range(0, N);
            cw[i1] = ~cw[i1];
            push(cw, pl, 1'b1, 1'b0);
        end
        drain();
        chk("sat_reached", 64'(corr_cnt), CNT_EN ? 64'(MAXC) : 64'(0));
        pl = K'($urandom());
        cw = encode(pl);
        cw[6] = ~cw[6];
        push(cw, pl, 1'b1, 1'b0);
        drain();
        chk("sat_held", 64'(corr_cnt), CNT_EN ? 64'(MAXC) : 64'(0));

        // Clear in the same cycle as a flagged handshake
        out_ready = 1'b0;
        pl = K'($urandom());
        cw = encode(pl);
        cw[9] = ~cw[9];
        push(cw, pl, 1'b1, 1'b0);
        guard = 0;
        while (!out_valid && guard < 10) begin tick(); guard++; end
        chk("clr_word_ready", 64'(out_valid), 64'(1));
        out_ready = 1'b1;
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        tick();
        chk("clr_priority", 64'(corr_cnt), 64'(0));

        // Reset mid-stream discards in-flight words
        for (int i = 0; i < 3; i++) begin
            pl = K'($urandom());
            cw = encode(pl);
            cw[0] = ~cw[0];
            push(cw, pl, 1'b1, 1'b0);
        end
        tick(); tick();
        do_reset();
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk("midrst_corr_cnt", 64'(corr_cnt), 64'(0));
        tick(); tick();
        chk("midrst_no_output", 64'(out_valid), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hamming_secded_decoder.md
# hamming_secded_decoder

Parametrised, pipelined Hamming SEC-DED decoder for the PUF response path. It extends the fixed 15-bit single-error decoder to any Hamming(2^R−1, 2^R−1−R) code plus one overall-parity bit. It corrects single-bit errors and detects double-bit errors. It sits between the helper-data reconstruction stage and the key-derivation stage, with valid/ready handshakes on both sides and optional saturating error counters for PUF-health monitoring.

## Interface
Parameters:
- `R`, default 4: Hamming parity-bit count, legal range 3..6. Derived values: N = 2^R−1 and K = N−R.
- `CNT_W`, default 16: width of each error counter.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  codeword present on `c_in`.
- `in_ready`  out  1  block accepts `c_in` this cycle.
- `c_in`  in  [0:N]  indices 0..N−1 hold Hamming positions 1..N (position = index+1); index N holds the overall parity bit.
- `out_valid`  out  1  decoded word present.
- `out_ready`  in  1  consumer accepts `data_out`.
- `data_out`  out  [0:K−1]  corrected data, taken from the non-power-of-two positions in ascending order. For R=4: positions 3,5,6,7,9..15.
- `corrected`  out  1  a single error was corrected, including an error in a parity bit.
- `uncorrectable`  out  1  a double error was detected.
- `cnt_clr`  in  1  synchronous clear of both counters.
- `corr_cnt`  out  CNT_W  saturating count of delivered words with `corrected`=1.
- `uncorr_cnt`  out  CNT_W  saturating count of delivered words with `uncorrectable`=1.

## Operation
- Syndrome: s[j] = XOR of all bits at positions p (1..N) with bit j of p set. All sums are modulo-2 XOR, not integer addition.
- Overall parity: P = XOR of all N+1 input bits.
- Classification:
  - s=0, P=0: clean. Pass the data unchanged; both flags 0.
  - s≠0, P=1: single error at position s. Invert that bit, then extract; `corrected`=1.
  - s=0, P=1: error in the overall parity bit. Data unchanged; `corrected`=1.
  - s≠0, P=0: double error. Data is extracted uncorrected, with no bit flipped; `uncorrectable`=1.
- Since N = 2^R−1, any s≠0 maps to a valid position. No out-of-range case exists.
- Pipeline:
  - Stage 1 registers `c_in`, s and P.
  - Stage 2 registers the corrected data and the flags.
  - Each stage has its own valid bit.
- Flow control:
  - A stage loads when it is empty or when its contents move forward in the same cycle.
  - `in_ready` = !s1_valid || !s2_valid || out_ready. This is combinational from `out_ready` and must not depend on `in_valid`.
  - While `out_valid`=1 and `out_ready`=0, `data_out`, `corrected` and `uncorrectable` hold stable.
- Counters:
  - A counter increments only on the output handshake (out_valid && out_ready) of a flagged word.
  - A counter saturates at 2^CNT_W−1.
  - `cnt_clr` takes priority over a same-cycle increment; the result is 0.

## Timing
- Latency: a word accepted in cycle t appears with `out_valid` in cycle t+2 when there are no stalls.
- Throughput: one word per cycle when `out_ready` is held at 1.
- Reset values: `out_valid`=0, `data_out`=0, `corrected`=0, `uncorrectable`=0, `corr_cnt`=0, `uncorr_cnt`=0. Internal valid bits are cleared to 0.
- Reset mid-operation: any in-flight words are discarded, and no counter is updated in the reset cycle.
- While `rst`=1, `in_ready` is 0. It may assert in the first cycle after `rst` deasserts.
- Back-pressure: with `out_ready`=0, the pipeline absorbs exactly two words. `in_ready` drops in the cycle after both stages are full.

## Configuration
- Macro: `ECC_ERR_CNT_EN`.
- Defined: `cnt_clr`, `corr_cnt` and `uncorr_cnt` behave as described above.
- Undefined:
  - No counter registers are synthesised.
  - `corr_cnt` and `uncorr_cnt` are tied to 0, and `cnt_clr` is ignored.
  - Ports and all other behaviour are unchanged.

## Test plan
- Reset, clean word: R=4, all-zero codeword with parity 0 and `out_ready`=1. Expect `data_out`=0, both flags 0, and output valid exactly 2 cycles after acceptance.
- Single-error sweep: for a random 11-bit payload, encode it, then flip each of the 16 bits in turn. Expect the original payload every time with `corrected`=1. `corr_cnt` reaches 16.
- Double error: flip positions 3 and 5 of an encoded word. Expect `uncorrectable`=1, `corrected`=0, `data_out` equal to the raw extracted bits, and `uncorr_cnt`+1.
- Back-pressure: stream 5 words with `out_ready`=0 for 4 cycles. Expect `in_ready` low after two acceptances, stable held outputs, then all 5 words delivered in order with none lost or duplicated.
- Counter edges: preload 2^CNT_W−1 corrections, then send one more. Expect the counter to stay saturated. Assert `cnt_clr` in the same cycle as a flagged handshake; expect the counter to read 0.
- Parametrisation: with R=3 and R=5, repeat the clean, single-error and double-error checks. Build once without `ECC_ERR_CNT_EN` and check that both counters read 0 throughout.
